if_prefetch_stage: RTL

Parametrised instruction-fetch stage with a prefetch buffer. It replaces the single-instruction fetch FSM between the instruction memory port (req/gnt/rvalid) and the ID stage. It supports up to MAX_OUTSTANDING pipelined memory requests, buffers up to FIFO_DEPTH fetched instructions with their PCs, and hands them to ID over a valid/ready handshake. Branch/jump redirects flush the buffer and discard in-flight responses.

---
 rtl/if_prefetch_stage_if.sv | 35 +++
 rtl/if_prefetch_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_prefetch_stage_if
// Bundles the two handshakes of the instruction-fetch prefetch stage:
//   - instruction memory port : instr_req_o / instr_addr_o  (stage -> memory)
//                               instr_gnt_i / instr_rvalid_i / instr_rdata_i
//                               (memory -> stage)
//   - ID stage port           : instr_valid_o / instr_o / pc_o (stage -> ID)
//                               instr_ready_i (ID -> stage)
// Modports:
//   master : the fetch stage (drives req/addr and the ID-side outputs)
//   slave  : the environment (memory + ID) on the other side
// -----------------------------------------------------------------------------
interface if_prefetch_stage_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  instr_req_o;
    logic [WORD_WIDTH-1:0] instr_addr_o;
    logic                  instr_gnt_i;
    logic                  instr_rvalid_i;
    logic [WORD_WIDTH-1:0] instr_rdata_i;
    logic                  instr_valid_o;
    logic                  instr_ready_i;
    logic [WORD_WIDTH-1:0] instr_o;
    logic [WORD_WIDTH-1:0] pc_o;

    modport master (
        output instr_req_o, instr_addr_o, instr_valid_o, instr_o, pc_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_ready_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o, instr_valid_o, instr_o, pc_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_ready_i
    );
endinterface

// File: rtl/if_prefetch_stage.sv
// -----------------------------------------------------------------------------
// if_prefetch_stage
// Instruction-fetch stage with a prefetch buffer. Issues up to MAX_OUTSTANDING
// pipelined requests to instruction memory, buffers up to FIFO_DEPTH returned
// words together with their PCs and hands them to ID over valid/ready.
// A redirect flushes the buffer and drops every response still in flight.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   fetch_en_i           permits issuing new requests
//   pc_start_address_i   boot address, loaded while rst_n=0
//   redirect_i           branch/jump taken: flush and refetch
//   redirect_addr_i      new fetch address
//   busy_o               requests in flight or FSM in FETCH
//   bus (master)         memory req/gnt/rvalid port and ID valid/ready port
// -----------------------------------------------------------------------------
module if_prefetch_stage #(
    parameter int WORD_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_en_i,
    input  logic [WORD_WIDTH-1:0]  pc_start_address_i,
    input  logic                   redirect_i,
    input  logic [WORD_WIDTH-1:0]  redirect_addr_i,
    output logic                   busy_o,
    if_prefetch_stage_if.master    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

    function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] a);
        return {a[WORD_WIDTH-1:2], 2'b00};
    endfunction

    // PC-tag FIFO depth need not be a power of two, so wrap explicitly.
    function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] p);
        return (p == TAG_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] fetch_addr_q;
    logic [WORD_WIDTH-1:0] held_addr_q;
    logic                  hold_q;      // last cycle's request was not granted
    logic                  stale_q;     // held request belongs to a flushed stream
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    logic [OUT_W-1:0]      discard_q;
    logic [CNT_W-1:0]      count_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [TAG_W-1:0]      tag_wr_q, tag_rd_q;

    logic [WORD_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] instr_mem [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] tag_mem   [MAX_OUTSTANDING];

    logic credit, req, valid;
    logic gnt, rvalid, pending, push, pop;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: leave FETCH only once no request is left hanging
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en_i) state_d = FETCH;
            FETCH:   if (!fetch_en_i && !pending) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        // Credit counts both buffered and in-flight words so a response
        // always finds a free slot.
        credit = (32'(outstanding_q) < 32'(MAX_OUTSTANDING)) &&
                 ((32'(count_q) + 32'(outstanding_q)) < 32'(FIFO_DEPTH));
        req    = hold_q || ((state_q == FETCH) && credit);
        valid  = (count_q != '0);

        bus.instr_req_o   = req;
        bus.instr_addr_o  = stale_q ? held_addr_q : fetch_addr_q;
        bus.instr_valid_o = valid;
        bus.instr_o       = valid ? instr_mem[rd_ptr_q] : '0;
        bus.pc_o          = valid ? pc_mem[rd_ptr_q]    : '0;
        busy_o            = (outstanding_q != '0) || (state_q == FETCH);
    end

    // Per-cycle transaction accounting
    always_comb begin
        gnt     = bus.instr_gnt_i && req;
        rvalid  = bus.instr_rvalid_i;
        pending = req && !gnt;
        push    = rvalid && (discard_q == '0) && !redirect_i;
        pop     = valid && bus.instr_ready_i && !redirect_i;

        outstanding_d = outstanding_q;
        if (gnt && !rvalid)      outstanding_d = outstanding_q + 1'b1;
        else if (!gnt && rvalid) outstanding_d = outstanding_q - 1'b1;
    end

    // Control state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_addr_q  <= word_align(pc_start_address_i);
            hold_q        <= 1'b0;
            stale_q       <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            hold_q        <= pending;
            outstanding_q <= outstanding_d;

            // A request caught by a redirect before its grant still goes out
            // at its old address; the new stream waits behind it.
            if (gnt)                    stale_q <= 1'b0;
            else if (redirect_i && req) stale_q <= 1'b1;

            if (redirect_i)             fetch_addr_q <= word_align(redirect_addr_i);
            else if (gnt && !stale_q)   fetch_addr_q <= fetch_addr_q + WORD_WIDTH'(4);

            // Everything in flight after this cycle, plus an ungranted
            // request, belongs to the flushed stream.
            if (redirect_i)                       discard_q <= outstanding_d + OUT_W'(pending);
            else if (rvalid && discard_q != '0)   discard_q <= discard_q - 1'b1;

            if (gnt)    tag_wr_q <= tag_next(tag_wr_q);
            if (rvalid) tag_rd_q <= tag_next(tag_rd_q);

            if (redirect_i) begin
                count_q  <= '0;
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage
    always_ff @(posedge clk) begin
        if (gnt) tag_mem[tag_wr_q] <= bus.instr_addr_o;
        if (push) begin
            pc_mem[wr_ptr_q]    <= tag_mem[tag_rd_q];
            instr_mem[wr_ptr_q] <= bus.instr_rdata_i;
        end
        if (redirect_i && pending) held_addr_q <= bus.instr_addr_o;
    end
endmodule
